uart_rx_bit_timer: RTL

//  Parametrised successor to the fixed-rate Rx sampling strobe: a frame-aware bit timer.

---
 rtl/uart_rx_bit_timer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: frame-aware UART receive bit timer.
// Takes the start-edge pulse from the start-bit detector and a runtime baud
// divisor. Produces one sampling strobe at the midpoint of every start, data
// and stop bit, and flags false starts and framing errors.
// Optional build macro MAJORITY_VOTE_EN: when defined, each sampled bit is the
// majority of the line over the three cycles ending at the sample point.
// Otherwise each sampled bit is a single capture taken at the sample point.
module uart_rx_bit_timer #(
    parameter int DIV_WIDTH = 16,
    parameter int DATA_BITS = 8,
    parameter int MIN_DIV   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DIV_WIDTH-1:0]              clocks_per_bit,
    input  logic                              start_detected,
    input  logic                              rx_serial,
    output logic                              sampling_strobe,
    output logic [$clog2(DATA_BITS+2)-1:0]    bit_index,
    output logic                              sampled_bit,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              start_error,
    output logic                              frame_error
);

    localparam int IDX_W = $clog2(DATA_BITS+2);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W  = DIV_WIDTH'(MIN_DIV);
    localparam logic [IDX_W-1:0]     LAST_DATA  = IDX_W'(DATA_BITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]           state;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] counter;
    logic [DIV_WIDTH-1:0] term_count;
    logic [IDX_W-1:0]     next_index;
    logic                 line_sample;
    logic                 frame_ending;

`ifdef MAJORITY_VOTE_EN
    logic [1:0] rx_history;

    // Keep the two previous line values so the sample point can vote over three cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_history <= 2'b11;
        end else begin
            rx_history <= {rx_history[0], rx_serial};
        end
    end

    // Majority of the line over the cycles counter==TC-2, TC-1 and TC.
    always_comb begin
        line_sample = (rx_history[1] & rx_history[0]) |
                      (rx_history[1] & rx_serial)     |
                      (rx_history[0] & rx_serial);
    end
`else
    // Single capture of the line at the sample point.
    always_comb begin
        line_sample = rx_serial;
    end
`endif

    // The start bit is sampled after half a bit; every later bit one full bit apart.
    always_comb begin
        if (state == S_START) begin
            term_count = (div_reg >> 1) - DIV_WIDTH'(1);
        end else begin
            term_count = div_reg - DIV_WIDTH'(1);
        end
    end

    // A strobe that ends the frame (false start or stop bit) returns to idle one cycle later.
    always_comb begin
        frame_ending = ((state == S_START) && start_error) ||
                       ((state == S_STOP)  && frame_done);
    end

    // Frame sequencing, bit counting and registered strobe/flag generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            counter         <= '0;
            div_reg         <= MIN_DIV_W;
            next_index      <= '0;
            sampling_strobe <= 1'b0;
            bit_index       <= '0;
            sampled_bit     <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            start_error     <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            sampling_strobe <= 1'b0;
            frame_done      <= 1'b0;
            start_error     <= 1'b0;
            frame_error     <= 1'b0;

            case (state)
                S_IDLE: begin
                    counter <= '0;
                    if (start_detected) begin
                        div_reg    <= (clocks_per_bit < MIN_DIV_W) ? MIN_DIV_W : clocks_per_bit;
                        next_index <= '0;
                        busy       <= 1'b1;
                        state      <= S_START;
                    end
                end
                default: begin
                    if (frame_ending) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        counter <= '0;
                    end else if (counter == term_count) begin
                        counter         <= '0;
                        sampling_strobe <= 1'b1;
                        sampled_bit     <= line_sample;
                        bit_index       <= next_index;
                        next_index      <= next_index + IDX_W'(1);
                        case (state)
                            S_START: begin
                                if (line_sample) begin
                                    start_error <= 1'b1;
                                end else begin
                                    state <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                if (next_index == LAST_DATA) begin
                                    state <= S_STOP;
                                end
                            end
                            default: begin
                                frame_done  <= 1'b1;
                                frame_error <= ~line_sample;
                            end
                        endcase
                    end else begin
                        counter <= counter + DIV_WIDTH'(1);
                    end
                end
            endcase
        end
    end

endmodule
